// File: rtl/ddr_axi_wr_sink.sv
// rtl/ddr_axi_wr_sink.sv - AXI4 write-channel slave that turns each burst into native single-cycle RAM writes
module ddr_axi_wr_sink #(
    parameter int ID_WIDTH       = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK = 32'h00001fff
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESETN,
    input  logic [ID_WIDTH-1:0]       AWID,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [ID_WIDTH-1:0]       BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic                      RAM_WEN,
    output logic [RAM_ADDR_WIDTH-1:0] RAM_WADDR,
    output logic [DATA_WIDTH-1:0]     RAM_WDATA,
    output logic [DATA_WIDTH/8-1:0]   RAM_WSTRB,
    output logic [31:0]               BURST_COUNT,
    output logic [31:0]               ERR_COUNT
);

    localparam logic [2:0] SIZE_LOG2 = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                    state, state_nxt;
    logic                      live;
    logic [ID_WIDTH-1:0]       id_q;
    logic [7:0]                len_q;
    logic [7:0]                beat_cnt;
    logic                      fixed_q;
    logic                      err_q;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic                      aw_hs, w_hs, b_hs, at_len, w_end;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign b_hs   = BVALID && BREADY;
    assign at_len = (beat_cnt == len_q);
    assign w_end  = w_hs && (WLAST || at_len);

    // live keeps AWREADY low through reset and raises it on the first edge after release
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_end) state_nxt = RESP;
            RESP:    if (b_hs)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (state)
            IDLE:    AWREADY = live;
            DATA:    WREADY  = 1'b1;
            RESP:    BVALID  = 1'b1;
            default: ;
        endcase
        BID   = id_q;
        BRESP = (state == RESP && err_q) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            id_q        <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            fixed_q     <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            RAM_WEN     <= 1'b0;
            RAM_WADDR   <= '0;
            RAM_WDATA   <= '0;
            RAM_WSTRB   <= '0;
            BURST_COUNT <= '0;
            ERR_COUNT   <= '0;
        end else begin
            RAM_WEN <= 1'b0;
            if (aw_hs) begin
                id_q     <= AWID;
                len_q    <= AWLEN;
                fixed_q  <= (AWBURST == 2'b00);
                err_q    <= AWBURST[1] || (AWSIZE != SIZE_LOG2);
                beat_cnt <= '0;
                addr_q   <= RAM_ADDR_WIDTH'((AWADDR & ADDR_MASK) >> SIZE_LOG2);
            end
            if (w_hs) begin
                // flagged bursts still drain their beats but never touch the RAM
                if (!err_q) begin
                    RAM_WEN   <= 1'b1;
                    RAM_WADDR <= addr_q;
                    RAM_WDATA <= WDATA;
                    RAM_WSTRB <= WSTRB;
                end
                addr_q   <= addr_q + RAM_ADDR_WIDTH'(fixed_q ? 0 : 1);
                beat_cnt <= beat_cnt + 8'd1;
                if (WLAST != at_len) begin
                    err_q <= 1'b1;
                end
            end
            if (b_hs) begin
                BURST_COUNT <= BURST_COUNT + 32'd1;
                if (err_q) begin
                    ERR_COUNT <= ERR_COUNT + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_axi_wr_sink.sv
// tb/tb_ddr_axi_wr_sink.sv - directed self-checking bench for ddr_axi_wr_sink
module tb_ddr_axi_wr_sink;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [15:0] WDATA = '0;
    logic [1:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [2:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic        RAM_WEN;
    logic [9:0]  RAM_WADDR;
    logic [15:0] RAM_WDATA;
    logic [1:0]  RAM_WSTRB;
    logic [31:0] BURST_COUNT;
    logic [31:0] ERR_COUNT;

    int cmp = 0;
    int errs = 0;
    int cyc = 0;

    typedef struct {
        int addr;
        int data;
        int strb;
        int cyc;
    } wr_t;
    wr_t wq[$];

    ddr_axi_wr_sink dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .RAM_WEN(RAM_WEN), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA), .RAM_WSTRB(RAM_WSTRB),
        .BURST_COUNT(BURST_COUNT), .ERR_COUNT(ERR_COUNT)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (RAM_WEN === 1'b1) wq.push_back('{int'(RAM_WADDR), int'(RAM_WDATA), int'(RAM_WSTRB), cyc});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        bit hs = 1'b0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        for (int j = 0; j < 100 && !hs; j++) begin
            hs = AWREADY;
            tick();
        end
        AWVALID = 1'b0;
        if (!hs) chk("aw_timeout", 0, 1);
        else chk("wready_after_aw", WREADY, 1);
    endtask

    task automatic w_burst(input int n, input logic [15:0] base, input int last_at, input bit gap);
        bit hs;
        for (int i = 0; i < n; i++) begin
            if (gap && (i % 2 == 1)) begin
                WVALID = 1'b0;
                tick();
            end
            WDATA = base + 16'(i); WSTRB = 2'b11; WLAST = (i == last_at); WVALID = 1'b1;
            hs = 1'b0;
            for (int j = 0; j < 100 && !hs; j++) begin
                hs = WREADY;
                tick();
            end
            if (!hs) chk("w_timeout", 0, 1);
        end
        WVALID = 1'b0;
        WLAST = 1'b0;
    endtask

    task automatic b_resp(input string tag, input logic [2:0] id, input logic [1:0] resp);
        bit hs = 1'b0;
        BREADY = 1'b1;
        for (int j = 0; j < 100 && !hs; j++) begin
            if (BVALID) begin
                chk({tag, "_bid"}, BID, id);
                chk({tag, "_bresp"}, BRESP, resp);
                hs = 1'b1;
            end
            tick();
        end
        BREADY = 1'b0;
        if (!hs) chk({tag, "_b_timeout"}, 0, 1);
        chk({tag, "_bvalid_drop"}, BVALID, 0);
        chk({tag, "_awready_back"}, AWREADY, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_awready"}, AWREADY, 0);
        chk({tag, "_wready"}, WREADY, 0);
        chk({tag, "_bvalid"}, BVALID, 0);
        chk({tag, "_bid"}, BID, 0);
        chk({tag, "_bresp"}, BRESP, 0);
        chk({tag, "_ram"}, {RAM_WEN, RAM_WADDR, RAM_WDATA, RAM_WSTRB}, 0);
        chk({tag, "_counts"}, {BURST_COUNT, ERR_COUNT}, 0);
    endtask

    initial begin
        int bad;
        rstn = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        rstn = 1'b1;
        tick();
        chk("awready_release", AWREADY, 1);

        // INCR burst, words 8..11 back to back
        wq.delete();
        aw(3'd5, 32'h1a800010, 8'd3, 3'd1, 2'b01);
        w_burst(4, 16'hA000, 3, 1'b0);
        chk("t1_wready_end", WREADY, 0);
        chk("t1_bvalid_end", BVALID, 1);
        b_resp("t1", 3'd5, 2'b00);
        chk("t1_nwr", wq.size(), 4);
        if (wq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", wq[i].addr, 8 + i);
                chk("t1_data", wq[i].data, 32'hA000 + i);
                chk("t1_strb", wq[i].strb, 3);
                chk("t1_consec", wq[i].cyc, wq[0].cyc + i);
            end
        end
        chk("t1_burst_count", BURST_COUNT, 1);

        // address wrap at 2^10 words
        wq.delete();
        aw(3'd1, 32'h000007fc, 8'd3, 3'd1, 2'b01);
        w_burst(4, 16'hB000, 3, 1'b0);
        b_resp("t2", 3'd1, 2'b00);
        chk("t2_nwr", wq.size(), 4);
        if (wq.size() == 4) begin
            chk("t2_a0", wq[0].addr, 1022);
            chk("t2_a1", wq[1].addr, 1023);
            chk("t2_a2", wq[2].addr, 0);
            chk("t2_a3", wq[3].addr, 1);
        end

        // early WLAST on beat 2, then a normal single-beat burst
        wq.delete();
        aw(3'd2, 32'h00000100, 8'd3, 3'd1, 2'b01);
        w_burst(2, 16'hC000, 1, 1'b0);
        chk("t3_bvalid_end", BVALID, 1);
        b_resp("t3", 3'd2, 2'b10);
        chk("t3_nwr", wq.size(), 2);
        chk("t3_err_count", ERR_COUNT, 1);
        wq.delete();
        aw(3'd3, 32'h00000200, 8'd0, 3'd1, 2'b01);
        w_burst(1, 16'hC100, 0, 1'b0);
        b_resp("t3b", 3'd3, 2'b00);
        chk("t3b_nwr", wq.size(), 1);
        if (wq.size() == 1) chk("t3b_addr", wq[0].addr, 32'h100);

        // WRAP burst type and wrong size are both drained silently with SLVERR
        wq.delete();
        aw(3'd4, 32'h0, 8'd1, 3'd1, 2'b10);
        w_burst(2, 16'hD000, 1, 1'b0);
        b_resp("t4w", 3'd4, 2'b10);
        aw(3'd4, 32'h0, 8'd1, 3'd0, 2'b01);
        w_burst(2, 16'hD100, 1, 1'b0);
        b_resp("t4s", 3'd4, 2'b10);
        chk("t4_nwr", wq.size(), 0);
        chk("t4_err_count", ERR_COUNT, 3);

        // BREADY held low: response stable, no new AW
        aw(3'd6, 32'h20, 8'd0, 3'd1, 2'b01);
        w_burst(1, 16'hE000, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold", {BVALID, BID, BRESP, AWREADY}, {1'b1, 3'd6, 2'b00, 1'b0});
            tick();
        end
        b_resp("t5", 3'd6, 2'b00);

        // 256-beat drain with bubbles
        wq.delete();
        aw(3'd7, 32'h00000400, 8'd255, 3'd1, 2'b01);
        w_burst(256, 16'h1000, 255, 1'b1);
        b_resp("t6", 3'd7, 2'b00);
        chk("t6_nwr", wq.size(), 256);
        bad = 0;
        foreach (wq[i]) begin
            if (wq[i].addr != ((512 + i) % 1024) || wq[i].data != 32'h1000 + i) bad++;
        end
        chk("t6_contig", bad, 0);
        chk("t6_burst_count", BURST_COUNT, 8);
        chk("t6_err_count", ERR_COUNT, 3);

        // reset mid-burst
        aw(3'd0, 32'h0, 8'd3, 3'd1, 2'b01);
        w_burst(2, 16'hF000, -1, 1'b0);
        rstn = 1'b0;
        tick();
        wq.delete();
        tick();
        check_reset_vals("mid_rst");
        rstn = 1'b1;
        tick();
        chk("t6_awready_release", AWREADY, 1);
        chk("t6_no_stray_wr", wq.size(), 0);
        aw(3'd1, 32'h40, 8'd3, 3'd1, 2'b01);
        w_burst(4, 16'h2000, 3, 1'b0);
        b_resp("t6r", 3'd1, 2'b00);
        chk("t6r_nwr", wq.size(), 4);
        if (wq.size() == 4) chk("t6r_addr0", wq[0].addr, 32);
        chk("t6r_burst_count", BURST_COUNT, 1);
        chk("t6r_err_count", ERR_COUNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule

// File: doc/ddr_axi_wr_sink.md
# ddr_axi_wr_sink

Synthesizable AXI4 write-channel slave that terminates the write bursts issued by `DDR_RING_BUFFER` on its DDR controller port. It converts each burst into native single-cycle RAM writes (enable/address/data/strobe) for an `SDPRAM`-style memory and returns one B response per burst. It is the downstream stage of the ring buffer and replaces the behavioural AXI-to-native model in benches and on FPGA targets without a DDR controller.

## Interface
- `ID_WIDTH`, 3, AXI ID width
- `ADDR_WIDTH`, 32, AXI address width
- `DATA_WIDTH`, 16, AXI/RAM data width (power of two, ≥8)
- `RAM_ADDR_WIDTH`, 10, native word-address width
- `ADDR_MASK`, 32'h00001fff, mask applied to AWADDR before word conversion

Ports:
- `S_AXI_ACLK`  in  1  clock
- `S_AXI_ARESETN`  in  1  reset, synchronous, active-low
- `AWID`  in  ID_WIDTH  burst ID
- `AWADDR`  in  ADDR_WIDTH  start byte address
- `AWLEN`  in  8  beats minus one
- `AWSIZE`  in  3  beat size
- `AWBURST`  in  2  burst type
- `AWVALID` in 1 / `AWREADY` out 1  AW handshake
- `WDATA`  in  DATA_WIDTH  beat data
- `WSTRB`  in  DATA_WIDTH/8  byte strobes
- `WLAST`  in  1  last beat
- `WVALID` in 1 / `WREADY` out 1  W handshake
- `BID`  out  ID_WIDTH  response ID
- `BRESP`  out  2  00 OKAY, 10 SLVERR
- `BVALID` out 1 / `BREADY` in 1  B handshake
- `RAM_WEN`  out  1  native write enable
- `RAM_WADDR`  out  RAM_ADDR_WIDTH  word address
- `RAM_WDATA`  out  DATA_WIDTH  write data
- `RAM_WSTRB`  out  DATA_WIDTH/8  byte enables
- `BURST_COUNT`  out  32  completed bursts (B handshakes)
- `ERR_COUNT`  out  32  bursts answered SLVERR

## Operation
- FSM states: IDLE, DATA, RESP. One outstanding burst; no read channels.
- IDLE: `AWREADY`=1. On AW handshake, capture ID, LEN, BURST, SIZE. Start word address = `(AWADDR & ADDR_MASK) >> log2(DATA_WIDTH/8)`, truncated to RAM_ADDR_WIDTH. Clear beat counter and error flag. Go to DATA.
- Burst check at AW: error flag is set when `AWBURST` ∉ {00 FIXED, 01 INCR} or when `AWSIZE` ≠ log2(DATA_WIDTH/8). A flagged burst has all beats consumed and all RAM writes suppressed.
- DATA: `WREADY`=1. Each W handshake issues a registered RAM write (if not flagged) with the current address, `WDATA`, and `WSTRB`. The address then increments by 1 for INCR and by 0 for FIXED, modulo 2^RAM_ADDR_WIDTH (wraps silently). The beat counter increments.
- Burst end is the earlier of a beat with `WLAST`=1 or beat number `AWLEN`+1. On mismatch (WLAST early, or missing at beat AWLEN+1), set the error flag. Writes already issued stand. Go to RESP.
- RESP: `BVALID`=1, `BID`=captured ID, `BRESP`=10 if flagged else 00. Values are held stable until `BREADY`. On B handshake, `BURST_COUNT`+1, `ERR_COUNT`+1 if flagged, go to IDLE.
- Counters wrap at 2^32.

## Timing
- Reset (`S_AXI_ARESETN`=0 at a clock edge): state IDLE. `AWREADY`=0 during reset, 1 in the first cycle after release. `WREADY`=0, `BVALID`=0, `BID`=0, `BRESP`=00, `RAM_WEN`=0, `RAM_WADDR`=0, `RAM_WDATA`=0, `RAM_WSTRB`=0, counters=0.
- Reset mid-burst aborts the burst: no B response and no further RAM writes. The master is reset with it.
- `AWREADY` and `WREADY` are registered state decodes, never dependent on VALID in the same cycle.
- AW handshake at cycle N → `WREADY`=1 from N+1.
- W handshake at cycle M → `RAM_WEN`=1 for exactly cycle M+1 with that beat's address/data/strobe. Back-to-back beats give consecutive write cycles.
- Final-beat handshake at M → `WREADY`=0 and `BVALID`=1 from M+1.
- B handshake at K → `BVALID`=0 and `AWREADY`=1 at K+1. Minimum burst turnaround is LEN+1+2 cycles.
- `WVALID` low inserts bubbles without error. `WVALID` in IDLE or RESP is not accepted.

## Test plan
- INCR, `AWADDR`=0x1a800010, `AWLEN`=3, `AWID`=5, data 0xA000..0xA003, strobe 11 → RAM writes at words 8,9,10,11 on consecutive cycles; `BID`=5, `BRESP`=00; `BURST_COUNT`=1.
- Address wrap: `AWADDR`=0x000007fc, `AWLEN`=3 → writes at words 1022,1023,0,1; OKAY.
- Early `WLAST` on beat 2 with `AWLEN`=3 → exactly 2 RAM writes; `BRESP`=10; `ERR_COUNT`=1; next burst accepted normally.
- `AWBURST`=10 (WRAP), `AWLEN`=1 → both beats accepted, `RAM_WEN` never asserted; SLVERR. The same outcome is required for `AWSIZE`=0.
- `BREADY` held low 5 cycles after `BVALID` → `BVALID`/`BID`/`BRESP` stable and `AWREADY`=0 throughout; `AWREADY`=1 the cycle after handshake.
- 256-beat INCR (ring-buffer drain length) with `WVALID` toggled every other beat, then reset asserted mid-second-burst → 256 writes at contiguous addresses, 1 OKAY. After reset, all outputs match reset values and a fresh 4-beat burst completes OKAY with `BURST_COUNT`=1.
